// File: rtl/ap3_readback_pkg.sv
// Shared types and helpers for the AP3 flip-flop readback block.
// READBACK_PARITY_EN adds a trailing even-parity bit to each frame.
package ap3_readback_pkg;

  localparam int unsigned MaxWidth = 1024;

`ifdef READBACK_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Callers zero-extend to MaxWidth, which leaves the XOR reduction unchanged.
  function automatic logic even_parity(input logic [MaxWidth-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/ap3_readback_shreg.sv
// Loadable shift register feeding the serial readback output.
// MSB_FIRST selects left shift from the top bit instead of right shift from bit 0.
module ap3_readback_shreg #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = '0;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/ap3_ff_readback.sv
// Captures a bank of AP3 flip-flop CQZ outputs and streams them out bit-serially.
// Optional READBACK_PARITY_EN appends an even-parity bit after the data bits.
module ap3_ff_readback
  import ap3_readback_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             cap_req,
  input  logic [WIDTH-1:0] cap_data,
  output logic             busy,
  output logic             cap_drop,
  output logic             sdo,
  output logic             sdo_valid,
  input  logic             sdo_ready,
  output logic             sdo_last,
  output logic             done
);

  localparam int unsigned     CntW    = cnt_w(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic            load, shift, sout, hs, last_data;

  assign hs        = sdo_valid & sdo_ready;
  assign last_data = (count_q == LastCnt);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cap_req) begin
          load    = 1'b1;
          count_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        drop_d = cap_req;
        if (hs) begin
          shift = 1'b1;
          if (last_data) begin
`ifdef READBACK_PARITY_EN
            state_d = StParity;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
`ifdef READBACK_PARITY_EN
      StParity: begin
        drop_d = cap_req;
        if (hs) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q <= StIdle;
      count_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  ap3_readback_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (QCK),
    .rst   (QRT),
    .load  (load),
    .shift (shift),
    .din   (cap_data),
    .sout  (sout)
  );

`ifdef READBACK_PARITY_EN
  logic parity_q;

  // Parity is frozen at capture so later cap_data changes cannot corrupt the frame.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= even_parity(MaxWidth'(cap_data));
    end
  end

  always_comb begin
    sdo = 1'b0;
    if (state_q == StShift) begin
      sdo = sout;
    end else if (state_q == StParity) begin
      sdo = parity_q;
    end
  end

  assign sdo_last = (state_q == StParity);
`else
  assign sdo      = (state_q == StShift) & sout;
  assign sdo_last = (state_q == StShift) & last_data;
`endif

  assign busy      = (state_q != StIdle);
  assign sdo_valid = busy;
  assign done      = done_q;
  assign cap_drop  = drop_q;

endmodule

// File: tb/tb_ap3_ff_readback.sv
// Directed bench: two 8-bit instances (LSB-first and MSB-first) share one stimulus stream.
module tb_ap3_ff_readback;

`ifdef READBACK_PARITY_EN
  localparam int NBits = 9;
`else
  localparam int NBits = 8;
`endif

  logic       QCK = 1'b0;
  logic       QRT;
  logic       cap_req;
  logic [7:0] cap_data;
  logic       sdo_ready;
  logic       busy0, cap_drop0, sdo0, sdo_valid0, sdo_last0, done0;
  logic       busy1, cap_drop1, sdo1, sdo_valid1, sdo_last1, done1;

  int tests = 0;
  int fails = 0;

  always #5 QCK = ~QCK;

  ap3_ff_readback #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .QCK       (QCK),
    .QRT       (QRT),
    .cap_req   (cap_req),
    .cap_data  (cap_data),
    .busy      (busy0),
    .cap_drop  (cap_drop0),
    .sdo       (sdo0),
    .sdo_valid (sdo_valid0),
    .sdo_ready (sdo_ready),
    .sdo_last  (sdo_last0),
    .done      (done0)
  );

  ap3_ff_readback #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .QCK       (QCK),
    .QRT       (QRT),
    .cap_req   (cap_req),
    .cap_data  (cap_data),
    .busy      (busy1),
    .cap_drop  (cap_drop1),
    .sdo       (sdo1),
    .sdo_valid (sdo_valid1),
    .sdo_ready (sdo_ready),
    .sdo_last  (sdo_last1),
    .done      (done1)
  );

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  // Pair checks: bit 1 is the MSB-first instance, bit 0 the LSB-first instance.
  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k, input bit msb);
    if (k >= 8) return ^d;
    return msb ? d[7-k] : d[k];
  endfunction

  task automatic check_all_zero(input string tag);
    check2({tag, "_busy"},  {busy1, busy0}, 2'b00);
    check2({tag, "_drop"},  {cap_drop1, cap_drop0}, 2'b00);
    check2({tag, "_sdo"},   {sdo1, sdo0}, 2'b00);
    check2({tag, "_valid"}, {sdo_valid1, sdo_valid0}, 2'b00);
    check2({tag, "_last"},  {sdo_last1, sdo_last0}, 2'b00);
    check2({tag, "_done"},  {done1, done0}, 2'b00);
  endtask

  task automatic frame(input logic [7:0] d, input bit stall, input bit drop);
    int k        = 0;
    int cyc      = 0;
    bit drop_now = 1'b0;
    bit drop_fired = 1'b0;
    cap_data  = d;
    cap_req   = 1'b1;
    sdo_ready = 1'b1;
    tick();
    cap_req = 1'b0;
    while (k < NBits && cyc < 200) begin
      check2($sformatf("drop_%02h_c%0d", d, cyc), {cap_drop1, cap_drop0},
             drop_now ? 2'b11 : 2'b00);
      check2($sformatf("valid_%02h_c%0d", d, cyc), {sdo_valid1, sdo_valid0}, 2'b11);
      check2($sformatf("busy_%02h_c%0d", d, cyc), {busy1, busy0}, 2'b11);
      check2($sformatf("done_%02h_c%0d", d, cyc), {done1, done0}, 2'b00);
      check2($sformatf("sdo_%02h_b%0d", d, k), {sdo1, sdo0},
             {exp_bit(d, k, 1'b1), exp_bit(d, k, 1'b0)});
      check2($sformatf("last_%02h_b%0d", d, k), {sdo_last1, sdo_last0},
             (k == NBits - 1) ? 2'b11 : 2'b00);
      sdo_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (drop && k == 2 && !drop_fired) begin
        cap_req    = 1'b1;
        cap_data   = ~d;
        drop_fired = 1'b1;
      end
      if (sdo_ready) k++;
      tick();
      cyc++;
      drop_now = cap_req;
      cap_req  = 1'b0;
    end
    checki($sformatf("bits_%02h", d), k, NBits);
    if (!stall) checki($sformatf("cycles_%02h", d), cyc, NBits);
    check2($sformatf("end_done_%02h", d), {done1, done0}, 2'b11);
    check2($sformatf("end_valid_%02h", d), {sdo_valid1, sdo_valid0}, 2'b00);
    check2($sformatf("end_busy_%02h", d), {busy1, busy0}, 2'b00);
    check2($sformatf("end_last_%02h", d), {sdo_last1, sdo_last0}, 2'b00);
  endtask

  initial begin
    QRT       = 1'b1;
    cap_req   = 1'b0;
    cap_data  = 8'h00;
    sdo_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    QRT = 1'b0;
    tick();
    check_all_zero("idle");

    frame(8'hA5, 1'b0, 1'b0);
    frame(8'h01, 1'b0, 1'b0);   // back-to-back: accepted in the done cycle
    tick();
    check2("done_clear", {done1, done0}, 2'b00);
    frame(8'hA5, 1'b1, 1'b0);   // backpressure
    frame(8'hA5, 1'b0, 1'b1);   // capture request while busy

    // Abort mid-frame after four handshakes.
    cap_data  = 8'hC3;
    cap_req   = 1'b1;
    sdo_ready = 1'b1;
    tick();
    cap_req = 1'b0;
    repeat (4) tick();
    check2("abort_valid", {sdo_valid1, sdo_valid0}, 2'b11);
    check2("abort_sdo", {sdo1, sdo0}, 2'b00);
    #2;
    QRT = 1'b1;
    #1;
    check_all_zero("abort");
    tick();
    QRT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero($sformatf("post_abort%0d", i));
    end
    frame(8'h01, 1'b0, 1'b0);
    frame(8'h07, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
